// File: rtl/mem_wb_stage.sv
// mem_wb_stage: final pipeline stage (MEM -> WB).
//
// Registers the MEM-stage result and drives the register-file write port.
// Load data from the synchronous data memory arrives one cycle after MEM
// presents the address. That is the same cycle the load sits in this stage,
// so byte/halfword extraction and extension are combinational on
// dmem_rdata. If WB stalls while holding a load, the first returned word is
// captured in a hold register. The memory output may change during the stall,
// and the captured word keeps the write data stable.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_wreg        MEM instruction writes a GPR
//   mem_waddr       destination register
//   mem_wdata       ALU / non-load result
//   mem_load_op     0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6-7 reserved
//   mem_addr_lo     byte offset of the load address
//   stall_mem       MEM stage stalled (bubble into WB unless WB also stalled)
//   stall_wb        WB stage stalled (hold)
//   flush           discard in-flight WB content
//   dmem_rdata      data memory read word (valid the cycle after the address)
//   wb_we           regfile write enable
//   wb_waddr        regfile write address
//   wb_wdata        regfile write data (also forwarded to ID)
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_load_op,
    input  logic [1:0]        mem_addr_lo,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata
);

    localparam logic [2:0] OpNone = 3'd0;
    localparam logic [2:0] OpLb   = 3'd1;
    localparam logic [2:0] OpLbu  = 3'd2;
    localparam logic [2:0] OpLh   = 3'd3;
    localparam logic [2:0] OpLhu  = 3'd4;
    localparam logic [2:0] OpLw   = 3'd5;

    // Stage registers
    logic              wreg_q,       wreg_d;
    logic [ADDR_W-1:0] waddr_q,      waddr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [2:0]        load_op_q,    load_op_d;
    logic [1:0]        addr_lo_q,    addr_lo_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q,  hold_data_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wreg_d       = wreg_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        load_op_d    = load_op_q;
        addr_lo_d    = addr_lo_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;

        if (rst || flush) begin
            wreg_d       = 1'b0;
            waddr_d      = '0;
            wdata_d      = '0;
            load_op_d    = OpNone;
            addr_lo_d    = 2'd0;
            hold_valid_d = 1'b0;
            hold_data_d  = '0;
        end else if (!stall_mem) begin
            // Normal advance. stall_wb=1 here cannot come from a legal
            // upstream, and it advances the same way.
            wreg_d       = mem_wreg;
            waddr_d      = mem_waddr;
            wdata_d      = mem_wdata;
            load_op_d    = mem_load_op;
            addr_lo_d    = mem_addr_lo;
            hold_valid_d = 1'b0;
        end else if (!stall_wb) begin
            // MEM stalled, WB free: the current WB op retires and a bubble
            // takes its place.
            wreg_d       = 1'b0;
            waddr_d      = '0;
            wdata_d      = '0;
            load_op_d    = OpNone;
            addr_lo_d    = 2'd0;
            hold_valid_d = 1'b0;
        end else if ((load_op_q != OpNone) && !hold_valid_q) begin
            // Both stalled: keep the stage. Capture the word the memory
            // returned for this load once, because dmem_rdata may move on.
            hold_data_d  = dmem_rdata;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        wreg_q       <= wreg_d;
        waddr_q      <= waddr_d;
        wdata_q      <= wdata_d;
        load_op_q    <= load_op_d;
        addr_lo_q    <= addr_lo_d;
        hold_valid_q <= hold_valid_d;
        hold_data_q  <= hold_data_d;
    end

    // ------------------------------------------------------------------
    // Load extraction (big-endian: offset 0 is the most significant byte)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] raw;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    assign raw = hold_valid_q ? hold_data_q : dmem_rdata;

    always_comb begin
        sel_byte = raw[31:24];
        unique case (addr_lo_q)
            2'd0: sel_byte = raw[31:24];
            2'd1: sel_byte = raw[23:16];
            2'd2: sel_byte = raw[15:8];
            2'd3: sel_byte = raw[7:0];
        endcase
    end

    // Only offsets 0 and 2 are aligned. Odd offsets are rejected below, so
    // bit 1 alone picks the half.
    assign sel_half = addr_lo_q[1] ? raw[15:0] : raw[31:16];

    // ------------------------------------------------------------------
    // Write-port outputs
    // ------------------------------------------------------------------
    logic              reject;
    logic [DATA_W-1:0] result;

    always_comb begin
        reject = 1'b0;
        result = wdata_q;
        case (load_op_q)
            OpNone: result = wdata_q;
            OpLb:   result = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
            OpLbu:  result = {{(DATA_W-8){1'b0}}, sel_byte};
            OpLh: begin
                result = {{(DATA_W-16){sel_half[15]}}, sel_half};
                reject = addr_lo_q[0];
            end
            OpLhu: begin
                result = {{(DATA_W-16){1'b0}}, sel_half};
                reject = addr_lo_q[0];
            end
            OpLw: begin
                result = raw;
                reject = (addr_lo_q != 2'd0);
            end
            default: reject = 1'b1;  // reserved encodings never write
        endcase
    end

    assign wb_we    = wreg_q & ~reject;
    assign wb_waddr = waddr_q;
    assign wb_wdata = reject ? '0 : result;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic [31:0] dmem_rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int n_total = 0;
    int n_bad   = 0;

    mem_wb_stage #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wreg   (mem_wreg),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_load_op(mem_load_op),
        .mem_addr_lo(mem_addr_lo),
        .stall_mem  (stall_mem),
        .stall_wb   (stall_wb),
        .flush      (flush),
        .dmem_rdata (dmem_rdata),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents of the WB slot plus the captured load word.
    logic        m_wreg  = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    int unsigned m_op    = 0;
    int unsigned m_lo    = 0;
    logic        m_hv    = 1'b0;
    logic [31:0] m_hd    = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected write port from the modelled WB slot and the live memory word.
    task automatic model_out(output logic we, output logic [31:0] d);
        logic [31:0] w;
        logic [31:0] v;
        logic        ok;
        w  = m_hv ? m_hd : dmem_rdata;
        ok = 1'b1;
        v  = m_wdata;
        case (m_op)
            0: v = m_wdata;
            1, 2: begin
                v = (w >> (24 - 8 * m_lo)) & 32'hFF;
                if (m_op == 1 && v >= 32'd128) v = v - 32'd256;
            end
            3, 4: begin
                if (m_lo % 2 == 1) ok = 1'b0;
                v = (w >> (16 - 8 * (m_lo & 2))) & 32'hFFFF;
                if (m_op == 3 && v >= 32'd32768) v = v - 32'd65536;
            end
            5: begin
                ok = (m_lo == 0);
                v  = w;
            end
            default: ok = 1'b0;
        endcase
        we = m_wreg && ok;
        d  = ok ? v : 32'd0;
    endtask

    task automatic model_clock();
        if (rst || flush) begin
            m_wreg = 0; m_waddr = 0; m_wdata = 0; m_op = 0; m_lo = 0; m_hv = 0; m_hd = 0;
        end else if (!stall_mem) begin
            m_wreg = mem_wreg; m_waddr = mem_waddr; m_wdata = mem_wdata;
            m_op = mem_load_op; m_lo = mem_addr_lo; m_hv = 0;
        end else if (!stall_wb) begin
            m_wreg = 0; m_waddr = 0; m_wdata = 0; m_op = 0; m_lo = 0; m_hv = 0;
        end else if (m_op != 0 && !m_hv) begin
            m_hd = dmem_rdata;
            m_hv = 1;
        end
    endtask

    // Called just after a posedge with inputs already driven for this cycle.
    // It compares outputs against the model, then advances one clock.
    task automatic tick();
        logic        e_we;
        logic [31:0] e_d;
        #1;
        model_out(e_we, e_d);
        check_val("we", {31'd0, wb_we}, {31'd0, e_we});
        check_val("waddr", {27'd0, wb_waddr}, {27'd0, m_waddr});
        check_val("wdata", wb_wdata, e_d);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [4:0] a,
                              input logic [31:0] d);
        #1;
        check_val({tag, "_we"}, {31'd0, wb_we}, {31'd0, we});
        check_val({tag, "_waddr"}, {27'd0, wb_waddr}, {27'd0, a});
        check_val({tag, "_wdata"}, wb_wdata, d);
    endtask

    task automatic set_instr(input logic w, input logic [4:0] a, input logic [31:0] d,
                             input logic [2:0] op, input logic [1:0] lo);
        mem_wreg = w; mem_waddr = a; mem_wdata = d; mem_load_op = op; mem_addr_lo = lo;
    endtask

    task automatic rand_instr();
        set_instr(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom));
    endtask

    // Loads checked against fixed values. The word is presented the cycle
    // after the load enters the stage.
    task automatic load_case(input string tag, input logic [2:0] op, input logic [1:0] lo,
                             input logic [31:0] exp);
        set_instr(1'b1, 5'd7, 32'h0BAD_0BAD, op, lo);
        tick();
        dmem_rdata = 32'h80F1_7F02;
        set_instr(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        expect_out(tag, 1'b1, 5'd7, exp);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
        rand_instr();
        dmem_rdata = $urandom;
        @(posedge clk);
        #1;

        // Reset with random inputs
        rand_instr();
        dmem_rdata = $urandom;
        flush = 1'($urandom); stall_mem = 1'($urandom);
        expect_out("rst", 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0; flush = 1'b0; stall_mem = 1'b0;
        set_instr(1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0);
        expect_out("rst2", 1'b0, 5'd0, 32'd0);
        tick();
        set_instr(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        expect_out("first", 1'b1, 5'd5, 32'h1234_5678);
        tick();

        load_case("lb0",  3'd1, 2'd0, 32'hFFFF_FF80);
        load_case("lbu1", 3'd2, 2'd1, 32'h0000_00F1);
        load_case("lb2",  3'd1, 2'd2, 32'h0000_007F);
        load_case("lh0",  3'd3, 2'd0, 32'hFFFF_80F1);
        load_case("lhu2", 3'd4, 2'd2, 32'h0000_7F02);
        load_case("lw",   3'd5, 2'd0, 32'h80F1_7F02);
        tick();

        // Stall hold on LW r9 while the memory word changes
        set_instr(1'b1, 5'd9, 32'd0, 3'd5, 2'd0);
        tick();
        set_instr(1'b1, 5'd10, 32'h55, 3'd0, 2'd0);
        stall_mem = 1'b1; stall_wb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_rdata = (i == 0) ? 32'hCAFE_BABE : 32'hDEAD_BEEF;
            expect_out("hold", 1'b1, 5'd9, 32'hCAFE_BABE);
            tick();
        end
        stall_mem = 1'b0; stall_wb = 1'b0;
        expect_out("hold_end", 1'b1, 5'd9, 32'hCAFE_BABE);
        tick();
        expect_out("release", 1'b1, 5'd10, 32'h55);

        // Bubble: MEM stalled, WB free
        set_instr(1'b1, 5'd11, 32'h77, 3'd0, 2'd0);
        stall_mem = 1'b1;
        tick();
        stall_mem = 1'b0;
        expect_out("bubble", 1'b0, 5'd0, 32'd0);
        tick();
        expect_out("after_bubble", 1'b1, 5'd11, 32'h77);

        // Misaligned and reserved
        dmem_rdata = 32'hFFFF_FFFF;
        set_instr(1'b1, 5'd12, 32'h99, 3'd3, 2'd1);
        tick();
        set_instr(1'b1, 5'd12, 32'h99, 3'd5, 2'd2);
        expect_out("lh_mis", 1'b0, 5'd12, 32'd0);
        tick();
        set_instr(1'b1, 5'd12, 32'h99, 3'd6, 2'd0);
        expect_out("lw_mis", 1'b0, 5'd12, 32'd0);
        tick();
        set_instr(1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        expect_out("resv", 1'b0, 5'd12, 32'd0);
        tick();

        // Flush overrides stall while holding an LW
        set_instr(1'b1, 5'd13, 32'd0, 3'd5, 2'd0);
        tick();
        dmem_rdata = 32'h1111_2222;
        set_instr(1'b1, 5'd14, 32'd0, 3'd2, 2'd3);
        stall_mem = 1'b1; stall_wb = 1'b1;
        tick();
        dmem_rdata = 32'h3333_3333;
        flush = 1'b1;
        expect_out("pre_flush", 1'b1, 5'd13, 32'h1111_2222);
        tick();
        flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
        expect_out("flush", 1'b0, 5'd0, 32'd0);
        tick();
        dmem_rdata = 32'h0000_00AB;
        expect_out("lbu_live", 1'b1, 5'd14, 32'h0000_00AB);
        tick();

        // Random legal traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rand_instr();
            dmem_rdata = $urandom;
            rst        = ($urandom_range(0, 49) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            stall_mem  = ($urandom_range(0, 3) == 0);
            stall_wb   = stall_mem && ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Final pipeline stage: registers the MEM-stage result and drives the register-file write port (we/waddr/wdata).
- Performs big-endian sub-word extraction and sign/zero extension of load data returned by the synchronous data memory (data valid one cycle after the address).
- Holds the load word across WB stalls.
- Applies pipeline stall and flush semantics.

Parameters:
DATA_W, 32, data/register width
ADDR_W, 5, register address width

Ports:
clk  input  1  clock
rst  input  1  reset
mem_wreg  input  1  MEM instruction writes a GPR
mem_waddr  input  ADDR_W  destination register
mem_wdata  input  DATA_W  ALU/non-load result
mem_load_op  input  3  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6-7 reserved
mem_addr_lo  input  2  byte offset of load address
stall_mem  input  1  MEM stage stalled
stall_wb  input  1  WB stage stalled
flush  input  1  discard in-flight WB content
dmem_rdata  input  DATA_W  data memory read word, valid the cycle after MEM presents the address
wb_we  output  1  regfile write enable
wb_waddr  output  ADDR_W  regfile write address
wb_wdata  output  DATA_W  regfile write data (also forwarded to ID)

Behaviour:
Reset: reset is rst, synchronous, active-high; clock is clk.
- On rst, all stage registers clear: wreg=0, waddr=0, wdata=0, load_op=NONE, addr_lo=0, hold_valid=0, hold_data=0.
- Result after reset: wb_we=0, wb_waddr=0, wb_wdata=0.

Stage register update, at posedge, in priority order:
1. rst or flush: clear, same values as reset.
2. stall_mem=1 and stall_wb=0: insert bubble (wreg=0, waddr=0, wdata=0, load_op=NONE).
3. stall_mem=0: capture all mem_* inputs.
4. Otherwise (both stalled): hold.
- stall_mem=0 with stall_wb=1 is illegal upstream and not checked; behaves as case 3.

Load hold register:
- At posedge, if stage load_op≠NONE, stall_wb=1 and hold_valid=0: hold_data<=dmem_rdata, hold_valid<=1.
- hold_valid clears whenever the stage register is written by case 1, 2 or 3.
- raw = hold_valid ? hold_data : dmem_rdata.

Output data, combinational from stage registers:
- NONE: wb_wdata = wdata.
- Byte select, big-endian: offset 0 = raw[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
- LB/LBU: selected byte, sign/zero-extended to DATA_W.
- Halfword select: offset 0 = raw[31:16], offset 2 = raw[15:0].
- LH/LHU: selected halfword, sign/zero-extended to DATA_W.
- LW: raw.

Output enable:
- wb_we = wreg, forced 0 for:
  - LH/LHU with addr_lo[0]=1;
  - LW with addr_lo≠0;
  - reserved load_op.
- In all forced-0 cases wb_wdata=0.
- wb_waddr = waddr always. A waddr=0 write is passed through; the regfile discards it.
- During WB stall the outputs stay constant. Repeated identical writes are permitted.

Latency: one cycle from mem_* inputs to wb_* outputs. Load data is extracted in the same cycle dmem_rdata arrives.

Simultaneous events: flush overrides stall; rst overrides all.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> wb_we=0, wb_waddr=0, wb_wdata=0; after release with mem_wreg=1, waddr=5, wdata=0x1234_5678, load_op=NONE -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x1234_5678.
2. Loads with dmem_rdata=0x80F1_7F02:
   - LB offset 0 -> 0xFFFF_FF80.
   - LBU offset 1 -> 0x0000_00F1.
   - LB offset 2 -> 0x0000_007F.
   - LH offset 0 -> 0xFFFF_80F1.
   - LHU offset 2 -> 0x0000_7F02.
   - LW -> 0x80F1_7F02.
3. Stall hold: LW to r9, then stall_wb=stall_mem=1 for 3 cycles while dmem_rdata changes from 0xCAFE_BABE to 0xDEAD_BEEF -> wb_wdata stays 0xCAFE_BABE, wb_we=1 throughout; on release the next instruction appears.
4. Bubble: stall_mem=1, stall_wb=0 with mem_wreg=1 -> next cycle wb_we=0, wb_waddr=0; held instruction enters when stall_mem drops.
5. Misaligned/reserved: LH offset 1, LW offset 2, load_op=6 -> wb_we=0, wb_wdata=0 each cycle.
6. Flush vs stall: flush=1 with stall_mem=stall_wb=1 while WB holds LW -> next cycle all outputs 0 and hold_valid cleared; a following LBU then reads live dmem_rdata.
